// File: rtl/hyperram_pkg.sv
// hyperram_pkg: shared types and constants for the HyperBus controller.
//   state_t     one-hot controller state
//   CA_*        command/address word layout (48 bits, sent MSB byte first)
//   WORD_BYTES  bytes per 32-bit data word
//   build_ca    assembles the CA word for a linear-burst access
//   word_lane   maps the n-th transferred byte to its lane in the 32-bit word
//   len_to_cnt  converts a phase length in cycles to a down-counter load value
package hyperram_pkg;

   typedef enum logic [6:0] {
      ST_IDLE = 7'b000_0001,
      ST_PRE  = 7'b000_0010,
      ST_CA   = 7'b000_0100,
      ST_LAT  = 7'b000_1000,
      ST_XFER = 7'b001_0000,
      ST_POST = 7'b010_0000,
      ST_CSH  = 7'b100_0000
   } state_t;

   localparam int CA_LEN       = 6;
   localparam int CA_W         = 8 * CA_LEN;
   localparam int CA_RW_BIT    = 47;
   localparam int CA_AS_BIT    = 46;
   localparam int CA_BURST_BIT = 45;
   localparam int CA_ROW_HI    = 44;
   localparam int CA_ROW_LO    = 16;
   localparam int CA_COL_HI    = 2;
   localparam int WORD_BYTES   = 4;
   localparam int CNT_W        = 8;

   function automatic logic [CA_W-1:0] build_ca(input logic wren,
                                                input logic regspace,
                                                input logic [31:0] addr);
      logic [CA_W-1:0] ca;
      ca                        = '0;
      ca[CA_RW_BIT]             = ~wren;
      ca[CA_AS_BIT]             = regspace;
      ca[CA_BURST_BIT]          = 1'b1;
      ca[CA_ROW_HI:CA_ROW_LO]   = {1'b0, addr[31:4]};
      ca[CA_COL_HI:0]           = addr[3:1];
      return ca;
   endfunction

   // Bytes travel as [15:8], [7:0], [31:24], [23:16]: lane = index ^ 1.
   function automatic logic [1:0] word_lane(input logic [1:0] idx);
      return idx ^ 2'b01;
   endfunction

   // A phase of N cycles loads N-1; zero-length phases collapse to one load of 0.
   function automatic logic [CNT_W-1:0] len_to_cnt(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

endpackage

// File: rtl/hyperram_lat_ctr.sv
// hyperram_lat_ctr: loadable down-counter timing the PRE, LAT, POST, CSH and
// read-timeout phases. Counts down to zero and holds there.
//   clk_i    system clock
//   rst_i    synchronous active-low reset
//   load_i   load value_i this cycle
//   value_i  load value (phase length minus one)
//   zero_o   counter is at zero (current phase ends this cycle)
module hyperram_lat_ctr
   import hyperram_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_reg <= '0;
      end else if (load_i) begin
         cnt_reg <= value_i;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign zero_o = (cnt_reg == '0);

endmodule

// File: rtl/hyperram_ctrl.sv
// hyperram_ctrl: single-word HyperBus controller. Turns one 32-bit request
// into one HyperBus transaction (CS#, CK, DQ[7:0], RWDS) with split pad signals.
//   clk_i/rst_i          system clock, synchronous active-low reset
//   valid_i..sel_i       request (held until ready_o)
//   tpre_i..trmax_i      runtime timing (clk_i cycles, tacc_i in CK cycles)
//   double/fixed_latency latency multiplier control
//   hb_dq_i, hb_rwds_i   pad inputs
//   ready_o, data_o      completion pulse and read data
//   hb_*_o               pad outputs, output enables, CK, CS#, device reset
module hyperram_ctrl
   import hyperram_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic        wren_i,
   input  logic        regspace_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  sel_i,
   input  logic [3:0]  tpre_i,
   input  logic [3:0]  tpost_i,
   input  logic [3:0]  tcsh_i,
   input  logic [3:0]  tacc_i,
   input  logic [4:0]  trmax_i,
   input  logic        double_latency_i,
   input  logic        fixed_latency_i,
   input  logic [7:0]  hb_dq_i,
   input  logic        hb_rwds_i,
   output logic        ready_o,
   output logic [31:0] data_o,
   output logic [7:0]  hb_dq_o,
   output logic        hb_dq_oe_o,
   output logic        hb_rwds_o,
   output logic        hb_rwds_oe_o,
   output logic        hb_ck_o,
   output logic        hb_csn_o,
   output logic        hb_rstn_o
);

   localparam logic [2:0] CA_LAST = 3'(CA_LEN - 1);

   state_t            state_reg, state_next;
   logic              wren_reg, regspace_reg;
   logic [CA_W-1:0]   ca_reg;
   logic [31:0]       wdata_reg, rdata_reg;
   logic [WORD_BYTES-1:0] sel_reg;
   logic [2:0]        byte_cnt_reg, byte_cnt_next;
   logic              tog_reg, tog_next;
   logic              ready_reg, ready_next;
   logic              rwds_prev_reg, rstn_reg;
   logic              cnt_load, cnt_zero;
   logic [CNT_W-1:0]  cnt_value, lat_len;
   logic              accept, capture, timeout, lat_mul2;
   logic              enter_xfer, xfer_done, enter_csh;
   logic [2:0]        xfer_last;
   logic [1:0]        lane;
   logic [7:0]        wr_byte [WORD_BYTES];

   genvar gi;
   generate
      for (gi = 0; gi < WORD_BYTES; gi++) begin : g_wr_lane
         assign wr_byte[gi] = wdata_reg[8*gi +: 8];
      end
   endgenerate

   hyperram_lat_ctr u_lat_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (cnt_load),
      .value_i (cnt_value),
      .zero_o  (cnt_zero)
   );

   assign lane      = word_lane(byte_cnt_reg[1:0]);
   assign xfer_last = regspace_reg ? 3'd1 : 3'd3;
   // RWDS is sampled on the last CA cycle to pick the latency multiplier.
   assign lat_mul2  = double_latency_i & (fixed_latency_i | hb_rwds_i);
   assign lat_len   = lat_mul2 ? {2'b00, tacc_i, 2'b00} : {3'b000, tacc_i, 1'b0};
   // Read data is strobed by either RWDS edge, seen as a change from last cycle.
   assign capture   = (state_reg == ST_XFER) && !wren_reg && (hb_rwds_i != rwds_prev_reg);

   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      tog_next      = 1'b0;
      cnt_load      = 1'b0;
      cnt_value     = '0;
      accept        = 1'b0;
      timeout       = 1'b0;
      enter_xfer    = 1'b0;
      xfer_done     = 1'b0;
      enter_csh     = 1'b0;
      ready_next    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (valid_i) begin
               accept = 1'b1;
               byte_cnt_next = '0;
               if (tpre_i != '0) begin
                  state_next = ST_PRE;
                  cnt_load   = 1'b1;
                  cnt_value  = len_to_cnt({4'b0000, tpre_i});
               end else begin
                  state_next = ST_CA;
               end
            end
         end
         ST_PRE: begin
            if (cnt_zero) state_next = ST_CA;
         end
         ST_CA: begin
            tog_next      = ~tog_reg;
            byte_cnt_next = byte_cnt_reg + 3'd1;
            if (byte_cnt_reg == CA_LAST) begin
               if ((wren_reg && regspace_reg) || (lat_len == '0)) begin
                  enter_xfer = 1'b1;
               end else begin
                  state_next = ST_LAT;
                  cnt_load   = 1'b1;
                  cnt_value  = lat_len - 1'b1;
               end
            end
         end
         ST_LAT: begin
            tog_next = ~tog_reg;
            if (cnt_zero) enter_xfer = 1'b1;
         end
         ST_XFER: begin
            tog_next = ~tog_reg;
            if (wren_reg) begin
               byte_cnt_next = byte_cnt_reg + 3'd1;
               if (byte_cnt_reg == xfer_last) xfer_done = 1'b1;
            end else if (capture) begin
               byte_cnt_next = byte_cnt_reg + 3'd1;
               cnt_load      = 1'b1;
               cnt_value     = len_to_cnt({3'b000, trmax_i});
               if (byte_cnt_reg == xfer_last) xfer_done = 1'b1;
            end else if (cnt_zero) begin
               timeout   = 1'b1;
               xfer_done = 1'b1;
            end
         end
         ST_POST: begin
            if (cnt_zero) enter_csh = 1'b1;
         end
         ST_CSH: begin
            if (cnt_zero) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      // The read timeout counter is armed on XFER entry; writes ignore it.
      if (enter_xfer) begin
         state_next    = ST_XFER;
         byte_cnt_next = '0;
         cnt_load      = 1'b1;
         cnt_value     = len_to_cnt({3'b000, trmax_i});
      end
      if (xfer_done) begin
         if (tpost_i != '0) begin
            state_next = ST_POST;
            cnt_load   = 1'b1;
            cnt_value  = len_to_cnt({4'b0000, tpost_i});
         end else begin
            enter_csh = 1'b1;
         end
      end
      // Completion is signalled in the first CS#-high cycle.
      if (enter_csh) begin
         state_next = ST_CSH;
         cnt_load   = 1'b1;
         cnt_value  = len_to_cnt({4'b0000, tcsh_i});
         ready_next = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_reg     <= ST_IDLE;
         wren_reg      <= 1'b0;
         regspace_reg  <= 1'b0;
         ca_reg        <= '0;
         wdata_reg     <= '0;
         sel_reg       <= '0;
         rdata_reg     <= '0;
         byte_cnt_reg  <= '0;
         tog_reg       <= 1'b0;
         ready_reg     <= 1'b0;
         rwds_prev_reg <= 1'b0;
         rstn_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         byte_cnt_reg  <= byte_cnt_next;
         tog_reg       <= tog_next;
         ready_reg     <= ready_next;
         rwds_prev_reg <= hb_rwds_i;
         rstn_reg      <= 1'b1;
         if (accept) begin
            wren_reg     <= wren_i;
            regspace_reg <= regspace_i;
            wdata_reg    <= data_i;
            sel_reg      <= sel_i;
            ca_reg       <= build_ca(wren_i, regspace_i, addr_i);
            rdata_reg    <= '0;
         end else if (state_reg == ST_CA) begin
            ca_reg <= {ca_reg[CA_W-9:0], 8'h00};
         end
         if (capture) begin
            rdata_reg[{lane, 3'b000} +: 8] <= hb_dq_i;
         end else if (timeout) begin
            rdata_reg <= '0;
         end
      end
   end

   always_comb begin
      hb_csn_o     = (state_reg == ST_IDLE) || (state_reg == ST_CSH);
      hb_ck_o      = tog_reg && ((state_reg == ST_CA) || (state_reg == ST_LAT) ||
                                 (state_reg == ST_XFER));
      hb_dq_oe_o   = (state_reg == ST_CA) || ((state_reg == ST_XFER) && wren_reg);
      hb_rwds_oe_o = (state_reg == ST_XFER) && wren_reg && !regspace_reg;
      hb_dq_o      = 8'h00;
      if (state_reg == ST_CA) begin
         hb_dq_o = ca_reg[CA_W-1 -: 8];
      end else if ((state_reg == ST_XFER) && wren_reg) begin
         hb_dq_o = wr_byte[lane];
      end
      hb_rwds_o = hb_rwds_oe_o ? ~sel_reg[lane] : 1'b0;
   end

   assign ready_o   = ready_reg;
   assign data_o    = rdata_reg;
   assign hb_rstn_o = rstn_reg;

endmodule

// File: tb/tb_hyperram_ctrl.sv
// tb_hyperram_ctrl: directed self-checking bench for hyperram_ctrl. Expected
// DQ/RWDS bytes and read words are queued when a request is driven and popped
// as the controller produces them.
module tb_hyperram_ctrl;

   typedef struct packed {
      logic [7:0] dq;
      logic       rwds_oe;
      logic       rwds;
   } exp_t;

   logic        clk;
   logic        rst_i, valid_i, wren_i, regspace_i;
   logic [31:0] addr_i, data_i;
   logic [3:0]  sel_i, tpre_i, tpost_i, tcsh_i, tacc_i;
   logic [4:0]  trmax_i;
   logic        double_latency_i, fixed_latency_i;
   logic [7:0]  hb_dq_i;
   logic        hb_rwds_i;
   logic        ready_o;
   logic [31:0] data_o;
   logic [7:0]  hb_dq_o;
   logic        hb_dq_oe_o, hb_rwds_o, hb_rwds_oe_o, hb_ck_o, hb_csn_o, hb_rstn_o;

   exp_t        exp_q[$];
   logic [31:0] exp_rd_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   hyperram_ctrl dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .valid_i          (valid_i),
      .wren_i           (wren_i),
      .regspace_i       (regspace_i),
      .addr_i           (addr_i),
      .data_i           (data_i),
      .sel_i            (sel_i),
      .tpre_i           (tpre_i),
      .tpost_i          (tpost_i),
      .tcsh_i           (tcsh_i),
      .tacc_i           (tacc_i),
      .trmax_i          (trmax_i),
      .double_latency_i (double_latency_i),
      .fixed_latency_i  (fixed_latency_i),
      .hb_dq_i          (hb_dq_i),
      .hb_rwds_i        (hb_rwds_i),
      .ready_o          (ready_o),
      .data_o           (data_o),
      .hb_dq_o          (hb_dq_o),
      .hb_dq_oe_o       (hb_dq_oe_o),
      .hb_rwds_o        (hb_rwds_o),
      .hb_rwds_oe_o     (hb_rwds_oe_o),
      .hb_ck_o          (hb_ck_o),
      .hb_csn_o         (hb_csn_o),
      .hb_rstn_o        (hb_rstn_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Transfer order of the word's byte lanes.
   function automatic int lane_of(input int i);
      case (i)
         0: return 1;
         1: return 0;
         2: return 3;
         default: return 2;
      endcase
   endfunction

   // One request; the bench acts as the device for reads, toggling RWDS once
   // per cycle starting exp_lat cycles after the last CA byte.
   task automatic run_txn(input string name, input logic wren, input logic regspace,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input logic [3:0] tacc,
                          input logic dbl, input logic fixed, input logic rwds_ca,
                          input int n_drive, input logic [31:0] drive_bytes,
                          input int exp_lat, input int exp_xfer,
                          input logic [31:0] exp_data);
      logic [47:0] ca;
      exp_t        e;
      int          cyc, ca_seen, k, drv, ckh, ck_bad, total, lane, nb;
      logic        done;
      ca = {~wren, regspace, 1'b1, 1'b0, addr[31:4], 13'd0, addr[3:1]};
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         e.dq = ca[47-8*i -: 8]; e.rwds_oe = 1'b0; e.rwds = 1'b0;
         exp_q.push_back(e);
      end
      if (wren) begin
         nb = regspace ? 2 : 4;
         for (int i = 0; i < nb; i++) begin
            lane      = lane_of(i);
            e.dq      = data[8*lane +: 8];
            e.rwds_oe = !regspace;
            e.rwds    = regspace ? 1'b0 : ~sel[lane];
            exp_q.push_back(e);
         end
      end else begin
         exp_rd_q.push_back(exp_data);
      end
      total = 1 + int'(tpre_i) + 6 + exp_lat + exp_xfer + int'(tpost_i);

      @(negedge clk);
      valid_i = 1'b1; wren_i = wren; regspace_i = regspace; addr_i = addr;
      data_i = data; sel_i = sel; tacc_i = tacc; double_latency_i = dbl;
      fixed_latency_i = fixed; hb_rwds_i = rwds_ca; hb_dq_i = 8'h00;

      cyc = 0; ca_seen = 0; k = -1; drv = 0; ckh = 0; ck_bad = 0; done = 1'b0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (hb_ck_o) ckh++;
         if (hb_ck_o && hb_csn_o) ck_bad++;
         if (hb_dq_oe_o) begin
            if (exp_q.size() == 0) begin
               chk({name, "_extra_byte"}, {24'h0, hb_dq_o}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk({name, "_dq"}, {24'h0, hb_dq_o}, {24'h0, e.dq});
               chk({name, "_rwds_oe"}, {31'h0, hb_rwds_oe_o}, {31'h0, e.rwds_oe});
               chk({name, "_rwds"}, {31'h0, hb_rwds_o}, {31'h0, e.rwds});
            end
            if (ca_seen < 6) ca_seen++;
         end else if (ca_seen == 6) begin
            k++;
            if (k < exp_lat) begin
               hb_rwds_i = 1'b0;
            end else if (drv < n_drive) begin
               hb_rwds_i = ~hb_rwds_i;
               hb_dq_i   = drive_bytes[31-8*drv -: 8];
               drv++;
            end
         end
         if (ready_o) begin
            done = 1'b1;
            valid_i = 1'b0;
            chk({name, "_latency"}, cyc, total);
            chk({name, "_csn_at_ready"}, {31'h0, hb_csn_o}, 32'd1);
            if (!wren) chk({name, "_rdata"}, data_o, exp_rd_q.pop_front());
            chk({name, "_bytes_left"}, exp_q.size(), 32'd0);
            chk({name, "_ck_high_cycles"}, ckh, (6 + exp_lat + exp_xfer) / 2);
            chk({name, "_ck_while_csn_high"}, ck_bad, 32'd0);
            $display("[TB] txn %s wren=%0b reg=%0b addr=%h cycles=%0d data_o=%h",
                     name, wren, regspace, addr, cyc, data_o);
         end
      end
      chk({name, "_ready_seen"}, {31'h0, done}, 32'd1);
      valid_i = 1'b0;
      @(negedge clk);
      chk({name, "_ready_single_pulse"}, {31'h0, ready_o}, 32'd0);
      chk({name, "_ck_low_after"}, {31'h0, hb_ck_o}, 32'd0);
      hb_rwds_i = 1'b0;
   endtask

   initial begin
      int cyc, n, low_at, rdy_cnt, csn_low_cnt;
      logic seen;
      rst_i = 1'b0; valid_i = 1'b0; wren_i = 1'b0; regspace_i = 1'b0;
      addr_i = '0; data_i = '0; sel_i = '0;
      tpre_i = 4'd1; tpost_i = 4'd1; tcsh_i = 4'd1; tacc_i = 4'd6; trmax_i = 5'd8;
      double_latency_i = 1'b0; fixed_latency_i = 1'b0; hb_dq_i = '0; hb_rwds_i = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_csn", {31'h0, hb_csn_o}, 32'd1);
      chk("rst_ck", {31'h0, hb_ck_o}, 32'd0);
      chk("rst_dq_oe", {31'h0, hb_dq_oe_o}, 32'd0);
      chk("rst_rwds_oe", {31'h0, hb_rwds_oe_o}, 32'd0);
      chk("rst_dq", {24'h0, hb_dq_o}, 32'd0);
      chk("rst_rwds", {31'h0, hb_rwds_o}, 32'd0);
      chk("rst_ready", {31'h0, ready_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_rstn_low", {31'h0, hb_rstn_o}, 32'd0);
      rst_i = 1'b1;
      @(negedge clk);
      chk("rst_rstn_high", {31'h0, hb_rstn_o}, 32'd1);
      chk("idle_csn", {31'h0, hb_csn_o}, 32'd1);
      repeat (2) @(negedge clk);

      // Memory write, full mask
      run_txn("mem_wr", 1'b1, 1'b0, 32'h0000_0010, 32'hAABB_CCDD, 4'hF, 4'd6,
              1'b0, 1'b0, 1'b0, 0, 32'h0, 12, 4, 32'h0);
      // Masked write
      run_txn("mask_wr", 1'b1, 1'b0, 32'h0000_0020, 32'h0123_4567, 4'h5, 4'd6,
              1'b0, 1'b0, 1'b0, 0, 32'h0, 12, 4, 32'h0);
      // Read with RWDS high in CA and double latency enabled
      run_txn("mem_rd_2x", 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 4'd6,
              1'b1, 1'b0, 1'b1, 4, 32'h1122_3344, 24, 4, 32'h3344_1122);
      // Fixed latency forces 2x even with RWDS low
      run_txn("mem_rd_fixed", 1'b0, 1'b0, 32'h0000_2468, 32'h0, 4'hF, 4'd3,
              1'b1, 1'b1, 1'b0, 4, 32'hA1B2_C3D4, 12, 4, 32'hC3D4_A1B2);
      // Double latency capable but RWDS low, not fixed: 1x
      run_txn("mem_rd_1x", 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0, 4'hF, 4'd3,
              1'b1, 1'b0, 1'b0, 4, 32'h5566_7788, 6, 4, 32'h7788_5566);
      // Register write: no latency, two bytes, RWDS not driven
      run_txn("reg_wr", 1'b1, 1'b1, 32'h0000_0000, 32'h0000_8F1F, 4'hF, 4'd6,
              1'b0, 1'b0, 1'b0, 0, 32'h0, 0, 2, 32'h0);
      // Register read: two captures into the low half
      run_txn("reg_rd", 1'b0, 1'b1, 32'h0000_0002, 32'h0, 4'hF, 4'd2,
              1'b0, 1'b0, 1'b0, 2, 32'hABCD_0000, 4, 2, 32'h0000_ABCD);
      // Read timeout: RWDS never toggles
      trmax_i = 5'd8;
      run_txn("rd_timeout", 1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 4'd2,
              1'b0, 1'b0, 1'b0, 0, 32'h0, 4, 8, 32'h0);

      // Valid held through ready: next access waits out CS# high time
      tcsh_i = 4'd4;
      repeat (2) @(negedge clk);
      valid_i = 1'b1; wren_i = 1'b1; regspace_i = 1'b0; addr_i = 32'h0000_0080;
      data_i = 32'hDEAD_BEEF; sel_i = 4'hF; tacc_i = 4'd1;
      double_latency_i = 1'b0; fixed_latency_i = 1'b0;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (ready_o) seen = 1'b1;
      end
      chk("b2b_ready_seen", {31'h0, seen}, 32'd1);
      chk("b2b_latency", cyc, 32'd15);
      n = 0; low_at = 0;
      while (low_at == 0 && n < 20) begin
         @(negedge clk);
         n++;
         if (!hb_csn_o) low_at = n;
      end
      chk("b2b_csn_high_cycles", low_at, 32'd5);
      $display("[TB] txn b2b_hold cycles=%0d csn_high_after_ready=%0d", cyc, low_at);

      // Reset in the middle of the second access
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      chk("midrst_csn", {31'h0, hb_csn_o}, 32'd1);
      chk("midrst_dq_oe", {31'h0, hb_dq_oe_o}, 32'd0);
      chk("midrst_ck", {31'h0, hb_ck_o}, 32'd0);
      chk("midrst_rstn", {31'h0, hb_rstn_o}, 32'd0);
      valid_i = 1'b0; rst_i = 1'b1;
      rdy_cnt = 0; csn_low_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready_o) rdy_cnt++;
         if (!hb_csn_o) csn_low_cnt++;
      end
      chk("midrst_no_ready", rdy_cnt, 32'd0);
      chk("midrst_stays_idle", csn_low_cnt, 32'd0);
      $display("[TB] txn mid_reset ready_pulses=%0d", rdy_cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
